// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage SimpleRisc pipeline (IF, OF, EX, MA, RW).
// Define HAZ_FORWARDING_EN when the datapath forwards, so that only load-use stalls.
module pipeline_hazard_ctrl #(
    parameter int unsigned MULTI_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       of_valid_i,
    input  logic [3:0] of_rs1_i,
    input  logic [3:0] of_rs2_i,
    input  logic       of_uses_rs1_i,
    input  logic       of_uses_rs2_i,
    input  logic       ex_valid_i,
    input  logic       ma_valid_i,
    input  logic       rw_valid_i,
    input  logic [3:0] ex_rd_i,
    input  logic [3:0] ma_rd_i,
    input  logic [3:0] rw_rd_i,
    input  logic       ex_wb_i,
    input  logic       ma_wb_i,
    input  logic       rw_wb_i,
    input  logic       ex_is_ld_i,
    input  logic       ex_is_multi_i,
    input  logic       ex_branch_taken_i,
    input  logic       ex_is_hlt_i,
    output logic       pc_en_o,
    output logic       pc_sel_branch_o,
    output logic       if_of_en_o,
    output logic       of_ex_en_o,
    output logic       ex_ma_en_o,
    output logic       if_of_flush_o,
    output logic       of_ex_bubble_o,
    output logic       ex_ma_bubble_o,
    output logic       halted_o,
    output logic [1:0] state_o
);

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StMulti = 2'd1;
    localparam logic [1:0] StHalt  = 2'd2;

    localparam bit         MultiEn = (MULTI_CYCLES > 1);
    // The RUN cycle that detects the op is the first stall, the zero-count cycle releases it.
    localparam logic [3:0] CntInit = MultiEn ? 4'(MULTI_CYCLES - 2) : 4'd0;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic ex_match;
    logic data_hazard;

    assign ex_match = of_valid_i & ex_valid_i & ex_wb_i &
                      ((of_uses_rs1_i & (of_rs1_i == ex_rd_i)) |
                       (of_uses_rs2_i & (of_rs2_i == ex_rd_i)));

`ifdef HAZ_FORWARDING_EN
    assign data_hazard = ex_match & ex_is_ld_i;
`else
    logic ma_match;
    logic rw_match;

    assign ma_match = of_valid_i & ma_valid_i & ma_wb_i &
                      ((of_uses_rs1_i & (of_rs1_i == ma_rd_i)) |
                       (of_uses_rs2_i & (of_rs2_i == ma_rd_i)));
    assign rw_match = of_valid_i & rw_valid_i & rw_wb_i &
                      ((of_uses_rs1_i & (of_rs1_i == rw_rd_i)) |
                       (of_uses_rs2_i & (of_rs2_i == rw_rd_i)));
    assign data_hazard = ex_match | ma_match | rw_match;
`endif

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pc_en_o         = 1'b1;
        pc_sel_branch_o = 1'b0;
        if_of_en_o      = 1'b1;
        of_ex_en_o      = 1'b1;
        ex_ma_en_o      = 1'b1;
        if_of_flush_o   = 1'b0;
        of_ex_bubble_o  = 1'b0;
        ex_ma_bubble_o  = 1'b0;
        halted_o        = 1'b0;

        case (state_q)
            StMulti: begin
                if (cnt_q != 4'd0) begin
                    pc_en_o        = 1'b0;
                    if_of_en_o     = 1'b0;
                    of_ex_en_o     = 1'b0;
                    ex_ma_bubble_o = 1'b1;
                    cnt_d          = cnt_q - 4'd1;
                end else begin
                    state_d = StRun;
                    if (data_hazard) begin
                        pc_en_o        = 1'b0;
                        if_of_en_o     = 1'b0;
                        of_ex_bubble_o = 1'b1;
                    end
                end
            end
            StHalt: begin
                pc_en_o        = 1'b0;
                if_of_en_o     = 1'b0;
                of_ex_bubble_o = 1'b1;
                halted_o       = 1'b1;
            end
            default: begin
                state_d = StRun;
                if (ex_valid_i & ex_branch_taken_i) begin
                    pc_sel_branch_o = 1'b1;
                    if_of_flush_o   = 1'b1;
                    of_ex_bubble_o  = 1'b1;
                end else if (ex_valid_i & ex_is_hlt_i) begin
                    pc_en_o        = 1'b0;
                    if_of_en_o     = 1'b0;
                    of_ex_bubble_o = 1'b1;
                    state_d        = StHalt;
                end else if (ex_valid_i & ex_is_multi_i & MultiEn) begin
                    pc_en_o        = 1'b0;
                    if_of_en_o     = 1'b0;
                    of_ex_en_o     = 1'b0;
                    ex_ma_bubble_o = 1'b1;
                    cnt_d          = CntInit;
                    state_d        = StMulti;
                end else if (data_hazard) begin
                    pc_en_o        = 1'b0;
                    if_of_en_o     = 1'b0;
                    of_ex_bubble_o = 1'b1;
                end
            end
        endcase

        // Freeze the whole pipeline while reset is held.
        if (reset) begin
            pc_en_o         = 1'b0;
            pc_sel_branch_o = 1'b0;
            if_of_en_o      = 1'b0;
            of_ex_en_o      = 1'b0;
            ex_ma_en_o      = 1'b0;
            if_of_flush_o   = 1'b0;
            of_ex_bubble_o  = 1'b0;
            ex_ma_bubble_o  = 1'b0;
            halted_o        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model of the stall rules.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       of_valid, of_uses_rs1, of_uses_rs2;
    logic [3:0] of_rs1, of_rs2;
    logic       ex_valid, ma_valid, rw_valid;
    logic [3:0] ex_rd, ma_rd, rw_rd;
    logic       ex_wb, ma_wb, rw_wb;
    logic       ex_is_ld, ex_is_multi, ex_branch_taken, ex_is_hlt;
    logic       pc_en, pc_sel_branch, if_of_en, of_ex_en, ex_ma_en;
    logic       if_of_flush, of_ex_bubble, ex_ma_bubble, halted;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: halted flag and EX cycles still owed by a multi-cycle op.
    bit m_halt = 1'b0;
    int m_busy = 0;

    pipeline_hazard_ctrl #(.MULTI_CYCLES(MC)) dut (
        .clk               (clk),
        .reset             (reset),
        .of_valid_i        (of_valid),
        .of_rs1_i          (of_rs1),
        .of_rs2_i          (of_rs2),
        .of_uses_rs1_i     (of_uses_rs1),
        .of_uses_rs2_i     (of_uses_rs2),
        .ex_valid_i        (ex_valid),
        .ma_valid_i        (ma_valid),
        .rw_valid_i        (rw_valid),
        .ex_rd_i           (ex_rd),
        .ma_rd_i           (ma_rd),
        .rw_rd_i           (rw_rd),
        .ex_wb_i           (ex_wb),
        .ma_wb_i           (ma_wb),
        .rw_wb_i           (rw_wb),
        .ex_is_ld_i        (ex_is_ld),
        .ex_is_multi_i     (ex_is_multi),
        .ex_branch_taken_i (ex_branch_taken),
        .ex_is_hlt_i       (ex_is_hlt),
        .pc_en_o           (pc_en),
        .pc_sel_branch_o   (pc_sel_branch),
        .if_of_en_o        (if_of_en),
        .of_ex_en_o        (of_ex_en),
        .ex_ma_en_o        (ex_ma_en),
        .if_of_flush_o     (if_of_flush),
        .of_ex_bubble_o    (of_ex_bubble),
        .ex_ma_bubble_o    (ex_ma_bubble),
        .halted_o          (halted),
        .state_o           (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    function automatic bit reads(input logic [3:0] r);
        return of_valid && ((of_uses_rs1 && of_rs1 == r) || (of_uses_rs2 && of_rs2 == r));
    endfunction

    function automatic bit model_hazard();
`ifdef HAZ_FORWARDING_EN
        return ex_valid && ex_wb && ex_is_ld && reads(ex_rd);
`else
        return (ex_valid && ex_wb && reads(ex_rd)) || (ma_valid && ma_wb && reads(ma_rd)) ||
               (rw_valid && rw_wb && reads(rw_rd));
`endif
    endfunction

    // Packed order: pc_en, pc_sel, if_of_en, of_ex_en, ex_ma_en, flush, of_ex_b, ex_ma_b, halted, state
    function automatic logic [10:0] pack(input bit pe, input bit ps, input bit ie, input bit oe,
                                         input bit ee, input bit fl, input bit ob, input bit eb,
                                         input bit h, input logic [1:0] st);
        return {pe, ps, ie, oe, ee, fl, ob, eb, h, st};
    endfunction

    // Compare process: mid-cycle, inputs are stable and the next edge will consume them.
    always @(negedge clk) begin
        logic [10:0] exp_v;
        if (reset) begin
            exp_v  = '0;
            m_halt = 1'b0;
            m_busy = 0;
        end else if (m_halt) begin
            exp_v = pack(0, 0, 0, 1, 1, 0, 1, 0, 1, 2'd2);
        end else if (m_busy > 1) begin
            exp_v  = pack(0, 0, 0, 0, 1, 0, 0, 1, 0, 2'd1);
            m_busy = m_busy - 1;
        end else if (m_busy == 1) begin
            exp_v  = model_hazard() ? pack(0, 0, 0, 1, 1, 0, 1, 0, 0, 2'd1)
                                    : pack(1, 0, 1, 1, 1, 0, 0, 0, 0, 2'd1);
            m_busy = 0;
        end else if (ex_valid && ex_branch_taken) begin
            exp_v = pack(1, 1, 1, 1, 1, 1, 1, 0, 0, 2'd0);
        end else if (ex_valid && ex_is_hlt) begin
            exp_v  = pack(0, 0, 0, 1, 1, 0, 1, 0, 0, 2'd0);
            m_halt = 1'b1;
        end else if (ex_valid && ex_is_multi && MC > 1) begin
            exp_v  = pack(0, 0, 0, 0, 1, 0, 0, 1, 0, 2'd0);
            m_busy = int'(MC) - 1;
        end else if (model_hazard()) begin
            exp_v = pack(0, 0, 0, 1, 1, 0, 1, 0, 0, 2'd0);
        end else begin
            exp_v = pack(1, 0, 1, 1, 1, 0, 0, 0, 0, 2'd0);
        end
        check("model", 32'(pack(pc_en, pc_sel_branch, if_of_en, of_ex_en, ex_ma_en, if_of_flush,
                                of_ex_bubble, ex_ma_bubble, halted, state)), 32'(exp_v));
    end

    task automatic idle();
        of_valid = 0; of_uses_rs1 = 0; of_uses_rs2 = 0; of_rs1 = 0; of_rs2 = 0;
        ex_valid = 0; ma_valid = 0; rw_valid = 0; ex_rd = 0; ma_rd = 0; rw_rd = 0;
        ex_wb = 0; ma_wb = 0; rw_wb = 0;
        ex_is_ld = 0; ex_is_multi = 0; ex_branch_taken = 0; ex_is_hlt = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    logic [3:0] exp_add [4];

    initial begin
        reset = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            check("reset_outputs", 32'({pc_en, if_of_en, of_ex_en, ex_ma_en, of_ex_bubble,
                                        ex_ma_bubble, if_of_flush, pc_sel_branch, halted, state}),
                  32'd0);
        end
        next_cycle();
        reset = 1'b0;
        sample();
        check("release_enables", 32'({pc_en, if_of_en, of_ex_en, ex_ma_en}), 32'hf);

        // Load r3 in EX, OF reads r3.
        next_cycle();
        ex_valid = 1; ex_wb = 1; ex_is_ld = 1; ex_rd = 3;
        of_valid = 1; of_uses_rs1 = 1; of_rs1 = 3;
        sample();
        check("load_use_stall", 32'({pc_en, if_of_en, of_ex_bubble}), 32'b001);
        next_cycle();
        ma_valid = 1; ma_wb = 1; ma_rd = 3;
        of_valid = 1; of_uses_rs1 = 1; of_rs1 = 3;
        sample();
`ifdef HAZ_FORWARDING_EN
        check("load_use_after", 32'({pc_en, if_of_en, of_ex_bubble}), 32'b110);
`else
        check("load_use_after", 32'({pc_en, if_of_en, of_ex_bubble}), 32'b001);
`endif

        // Taken branch beats a simultaneous load-use.
        next_cycle();
        ex_valid = 1; ex_wb = 1; ex_is_ld = 1; ex_rd = 3; ex_branch_taken = 1;
        of_valid = 1; of_uses_rs2 = 1; of_rs2 = 3;
        sample();
        check("branch_wins", 32'({pc_sel_branch, if_of_flush, of_ex_bubble, pc_en}), 32'hf);

        // Divide occupying EX for MC cycles.
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (i < 4) begin
                ex_valid = 1; ex_is_multi = 1; ex_wb = 1; ex_rd = 5;
            end
            sample();
            if (i < 3)
                check("multi_stall", 32'({pc_en, if_of_en, of_ex_en, ex_ma_bubble}), 32'b0001);
            else if (i == 3)
                check("multi_release", 32'({pc_en, if_of_en, of_ex_en, ex_ma_bubble}), 32'b1110);
            check("multi_state", 32'(state), (i == 1 || i == 2 || i == 3) ? 32'd1 : 32'd0);
        end

        // ALU producer of r1 walking EX -> MA -> RW while OF reads r1.
`ifdef HAZ_FORWARDING_EN
        exp_add = '{4'd1, 4'd1, 4'd1, 4'd1};
`else
        exp_add = '{4'd0, 4'd0, 4'd0, 4'd1};
`endif
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            of_valid = 1; of_uses_rs2 = 1; of_rs2 = 1;
            if (i == 0) begin ex_valid = 1; ex_wb = 1; ex_rd = 1; end
            if (i == 1) begin ma_valid = 1; ma_wb = 1; ma_rd = 1; end
            if (i == 2) begin rw_valid = 1; rw_wb = 1; rw_rd = 1; end
            sample();
            check("raw_pc_en", 32'(pc_en), 32'(exp_add[i]));
        end

        // hlt: sticky until reset.
        next_cycle();
        ex_valid = 1; ex_is_hlt = 1;
        sample();
        check("hlt_cycle", 32'({halted, pc_en, of_ex_bubble}), 32'b001);
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            sample();
            check("halted_hold", 32'({halted, pc_en}), 32'b10);
        end
        check("halt_state", 32'(state), 32'd2);
        next_cycle();
        reset = 1'b1;
        sample();
        check("halt_reset", 32'({halted, state}), 32'd0);
        next_cycle();
        reset = 1'b0;
        sample();
        check("halt_left", 32'({halted, state, pc_en}), 32'b0001);

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            reset = ($urandom_range(0, 59) == 0);
            of_valid = ($urandom_range(0, 3) != 0);
            of_uses_rs1 = $urandom_range(0, 1) != 0;
            of_uses_rs2 = $urandom_range(0, 1) != 0;
            of_rs1 = 4'($urandom_range(0, 3));
            of_rs2 = 4'($urandom_range(0, 3));
            ex_valid = ($urandom_range(0, 3) != 0);
            ma_valid = ($urandom_range(0, 3) != 0);
            rw_valid = ($urandom_range(0, 3) != 0);
            ex_rd = 4'($urandom_range(0, 3));
            ma_rd = 4'($urandom_range(0, 3));
            rw_rd = 4'($urandom_range(0, 3));
            ex_wb = $urandom_range(0, 1) != 0;
            ma_wb = $urandom_range(0, 1) != 0;
            rw_wb = $urandom_range(0, 1) != 0;
            ex_is_ld = $urandom_range(0, 2) == 0;
            ex_is_multi = $urandom_range(0, 7) == 0;
            ex_branch_taken = $urandom_range(0, 9) == 0;
            ex_is_hlt = $urandom_range(0, 79) == 0;
        end
        next_cycle();
        reset = 1'b0;
        sample();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
